// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam logic [15:0] DEF_VEC_BASE = 16'hFFE0;
    localparam int unsigned VEC_STRIDE   = 2;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: index of the highest set request bit plus a valid flag.
module irq_prio_enc #(
    parameter  int unsigned N_SRC = 8,
    localparam int unsigned IDW   = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    output logic [IDW-1:0]   id,
    output logic             valid
);

    // Ascending scan: the last (highest) set bit overwrites lower ones.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (req[i]) begin
                id    = IDW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Maskable fixed-priority interrupt controller with a non-nesting
// request / acknowledge / return handshake towards the CPU.
module interrupt_controller
    import irq_pkg::*;
#(
    parameter  int unsigned N_SRC    = 8,
    parameter  logic [15:0] VEC_BASE = DEF_VEC_BASE,
    localparam int unsigned IDW      = $clog2(N_SRC)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_SRC-1:0] IRQ,
    input  logic             IE_WE,
    input  logic [N_SRC-1:0] IE_WDATA,
    input  logic             GIE,
    input  logic             INT_ACK,
    input  logic             RETI,
    input  logic             OVF_CLR,
    output logic             INT_REQ,
    output logic [15:0]      VECTOR,
    output logic [IDW-1:0]   IRQ_ID,
    output logic [N_SRC-1:0] PENDING,
    output logic [N_SRC-1:0] IE,
    output logic [N_SRC-1:0] OVF
);

    irq_state_t       state;
    irq_state_t       state_nxt;
    logic [N_SRC-1:0] eligible;
    logic [IDW-1:0]   win_id;
    logic             win_valid;
    logic             ack_acc;
    logic             withdraw;
    logic             load_id;
    logic [N_SRC-1:0] clr_mask;
    logic [N_SRC-1:0] ovf_set;
    logic [15:0]      vec_c;

    assign eligible = GIE ? (PENDING & IE) : '0;

    irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
        .req   (eligible),
        .id    (win_id),
        .valid (win_valid)
    );

    // Ack is only honoured while a request is being presented.
    assign ack_acc  = (state == REQ) && INT_ACK;
    assign withdraw = !GIE || !IE[IRQ_ID];
    assign clr_mask = ack_acc ? (N_SRC'(1) << IRQ_ID) : '0;
    // A same-cycle ack of the bit suppresses overflow; the set still wins.
    assign ovf_set  = IRQ & PENDING & ~clr_mask;
    assign vec_c    = (VEC_BASE + 16'(VEC_STRIDE) * 16'(win_id)) & 16'hFFFE;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (INT_ACK) begin
                    state_nxt = SERVICE;
                end else if (withdraw) begin
                    state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (RETI) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        INT_REQ = 1'b0;
        load_id = 1'b0;
        if (state == REQ) begin
            INT_REQ = 1'b1;
        end
        if ((state == IDLE) && win_valid) begin
            load_id = 1'b1;
        end
    end

    // Pending/overflow latches, enable mask and the latched winner.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PENDING <= '0;
            OVF     <= '0;
            IE      <= '0;
            IRQ_ID  <= '0;
            VECTOR  <= VEC_BASE;
        end else begin
            PENDING <= (PENDING & ~clr_mask) | IRQ;
            OVF     <= (OVF_CLR ? '0 : OVF) | ovf_set;
            if (IE_WE) begin
                IE <= IE_WDATA;
            end
            if (load_id) begin
                IRQ_ID <= win_id;
                VECTOR <= vec_c;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed table-driven bench for interrupt_controller plus a reset sequence.
module tb_interrupt_controller;

    logic        CLK;
    logic        RST_N;
    logic [7:0]  IRQ;
    logic        IE_WE;
    logic [7:0]  IE_WDATA;
    logic        GIE;
    logic        INT_ACK;
    logic        RETI;
    logic        OVF_CLR;
    logic        INT_REQ;
    logic [15:0] VECTOR;
    logic [2:0]  IRQ_ID;
    logic [7:0]  PENDING;
    logic [7:0]  IE;
    logic [7:0]  OVF;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  irq;
        logic        we;
        logic [7:0]  wd;
        logic        gie;
        logic        ack;
        logic        reti;
        logic        oclr;
        logic        req;
        logic [2:0]  id;
        logic [15:0] vec;
        logic [7:0]  pend;
        logic [7:0]  ie;
        logic [7:0]  ovf;
    } vec_t;

    vec_t tbl[$];

    interrupt_controller #(.N_SRC(8), .VEC_BASE(16'hFFE0)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .IRQ      (IRQ),
        .IE_WE    (IE_WE),
        .IE_WDATA (IE_WDATA),
        .GIE      (GIE),
        .INT_ACK  (INT_ACK),
        .RETI     (RETI),
        .OVF_CLR  (OVF_CLR),
        .INT_REQ  (INT_REQ),
        .VECTOR   (VECTOR),
        .IRQ_ID   (IRQ_ID),
        .PENDING  (PENDING),
        .IE       (IE),
        .OVF      (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic [7:0] irq, input logic we, input logic [7:0] wd,
                                input logic gie, input logic ack, input logic reti, input logic oclr,
                                input logic req, input logic [2:0] id, input logic [15:0] vec,
                                input logic [7:0] pend, input logic [7:0] ie, input logic [7:0] ovf);
        vec_t v;
        v.irq = irq; v.we = we; v.wd = wd; v.gie = gie; v.ack = ack; v.reti = reti; v.oclr = oclr;
        v.req = req; v.id = id; v.vec = vec; v.pend = pend; v.ie = ie; v.ovf = ovf;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic req, input logic [2:0] id, input logic [15:0] vec,
                             input logic [7:0] pend, input logic [7:0] ie, input logic [7:0] ovf);
        check("int_req", idx, 16'(INT_REQ), 16'(req));
        check("irq_id",  idx, 16'(IRQ_ID),  16'(id));
        check("vector",  idx, VECTOR,       vec);
        check("pending", idx, 16'(PENDING), 16'(pend));
        check("ie",      idx, 16'(IE),      16'(ie));
        check("ovf",     idx, 16'(OVF),     16'(ovf));
    endtask

    task automatic drive(input logic [7:0] irq, input logic we, input logic [7:0] wd,
                         input logic gie, input logic ack, input logic reti, input logic oclr);
        IRQ = irq; IE_WE = we; IE_WDATA = wd; GIE = gie; INT_ACK = ack; RETI = reti; OVF_CLR = oclr;
    endtask

    initial begin
        // Rows: inputs for one cycle, then expected outputs just after that edge.
        // Single timer event
        tbl.push_back(mk(8'h00,1,8'h01,1,0,0,0, 0,3'd0,16'hFFE0,8'h00,8'h01,8'h00));
        tbl.push_back(mk(8'h01,0,8'h00,1,0,0,0, 0,3'd0,16'hFFE0,8'h01,8'h01,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,0, 1,3'd0,16'hFFE0,8'h01,8'h01,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,1,0,0, 0,3'd0,16'hFFE0,8'h00,8'h01,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,0, 0,3'd0,16'hFFE0,8'h00,8'h01,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,1,0, 0,3'd0,16'hFFE0,8'h00,8'h01,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,0, 0,3'd0,16'hFFE0,8'h00,8'h01,8'h00));
        // Priority between sources 2 and 5
        tbl.push_back(mk(8'h00,1,8'hFF,1,0,0,0, 0,3'd0,16'hFFE0,8'h00,8'hFF,8'h00));
        tbl.push_back(mk(8'h24,0,8'h00,1,0,0,0, 0,3'd0,16'hFFE0,8'h24,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,0, 1,3'd5,16'hFFEA,8'h24,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,1,0,0, 0,3'd5,16'hFFEA,8'h04,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,1,0, 0,3'd5,16'hFFEA,8'h04,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,0, 1,3'd2,16'hFFE4,8'h04,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,1,0,0, 0,3'd2,16'hFFE4,8'h00,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,1,0, 0,3'd2,16'hFFE4,8'h00,8'hFF,8'h00));
        // Masking and GIE withdrawal
        tbl.push_back(mk(8'h00,1,8'h00,1,0,0,0, 0,3'd2,16'hFFE4,8'h00,8'h00,8'h00));
        tbl.push_back(mk(8'h08,0,8'h00,1,0,0,0, 0,3'd2,16'hFFE4,8'h08,8'h00,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,0, 0,3'd2,16'hFFE4,8'h08,8'h00,8'h00));
        tbl.push_back(mk(8'h00,1,8'h08,1,0,0,0, 0,3'd2,16'hFFE4,8'h08,8'h08,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,0, 1,3'd3,16'hFFE6,8'h08,8'h08,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,0,0,0,0, 0,3'd3,16'hFFE6,8'h08,8'h08,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,0,0,0,0, 0,3'd3,16'hFFE6,8'h08,8'h08,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,0, 1,3'd3,16'hFFE6,8'h08,8'h08,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,1,0,0, 0,3'd3,16'hFFE6,8'h00,8'h08,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,1,0, 0,3'd3,16'hFFE6,8'h00,8'h08,8'h00));
        // Overflow, clear, and set-wins on ack
        tbl.push_back(mk(8'h00,1,8'hFF,1,0,0,0, 0,3'd3,16'hFFE6,8'h00,8'hFF,8'h00));
        tbl.push_back(mk(8'h02,0,8'h00,1,0,0,0, 0,3'd3,16'hFFE6,8'h02,8'hFF,8'h00));
        tbl.push_back(mk(8'h02,0,8'h00,1,0,0,0, 1,3'd1,16'hFFE2,8'h02,8'hFF,8'h02));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,1, 1,3'd1,16'hFFE2,8'h02,8'hFF,8'h00));
        tbl.push_back(mk(8'h02,0,8'h00,1,1,0,0, 0,3'd1,16'hFFE2,8'h02,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,1,0, 0,3'd1,16'hFFE2,8'h02,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,0, 1,3'd1,16'hFFE2,8'h02,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,1,0,0, 0,3'd1,16'hFFE2,8'h00,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,1,0, 0,3'd1,16'hFFE2,8'h00,8'hFF,8'h00));
        tbl.push_back(mk(8'h02,0,8'h00,1,0,0,0, 0,3'd1,16'hFFE2,8'h02,8'hFF,8'h00));
        tbl.push_back(mk(8'h02,0,8'h00,1,0,0,1, 1,3'd1,16'hFFE2,8'h02,8'hFF,8'h02));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,1, 1,3'd1,16'hFFE2,8'h02,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,1,0,0, 0,3'd1,16'hFFE2,8'h00,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,1,0, 0,3'd1,16'hFFE2,8'h00,8'hFF,8'h00));
        // Late higher-priority arrival does not re-arbitrate
        tbl.push_back(mk(8'h10,0,8'h00,1,0,0,0, 0,3'd1,16'hFFE2,8'h10,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,0, 1,3'd4,16'hFFE8,8'h10,8'hFF,8'h00));
        tbl.push_back(mk(8'h80,0,8'h00,1,0,0,0, 1,3'd4,16'hFFE8,8'h90,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,0, 1,3'd4,16'hFFE8,8'h90,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,1,0,0, 0,3'd4,16'hFFE8,8'h80,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,1,0, 0,3'd4,16'hFFE8,8'h80,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,0, 1,3'd7,16'hFFEE,8'h80,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,1,0,0, 0,3'd7,16'hFFEE,8'h00,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,1,0, 0,3'd7,16'hFFEE,8'h00,8'hFF,8'h00));
        // Stray ack/reti ignored, capture during SERVICE, IE withdrawal, ack beats withdrawal
        tbl.push_back(mk(8'h01,0,8'h00,0,0,0,0, 0,3'd7,16'hFFEE,8'h01,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,0,1,0,0, 0,3'd7,16'hFFEE,8'h01,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,0, 1,3'd0,16'hFFE0,8'h01,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,1,0, 1,3'd0,16'hFFE0,8'h01,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,1,0,0, 0,3'd0,16'hFFE0,8'h00,8'hFF,8'h00));
        tbl.push_back(mk(8'h01,0,8'h00,1,1,0,0, 0,3'd0,16'hFFE0,8'h01,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,1,0, 0,3'd0,16'hFFE0,8'h01,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,0, 1,3'd0,16'hFFE0,8'h01,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,1,8'h00,1,0,0,0, 1,3'd0,16'hFFE0,8'h01,8'h00,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,0, 0,3'd0,16'hFFE0,8'h01,8'h00,8'h00));
        tbl.push_back(mk(8'h00,1,8'hFF,1,1,0,0, 0,3'd0,16'hFFE0,8'h01,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,0,0, 1,3'd0,16'hFFE0,8'h01,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,0,1,0,0, 0,3'd0,16'hFFE0,8'h00,8'hFF,8'h00));
        tbl.push_back(mk(8'h00,0,8'h00,1,0,1,0, 0,3'd0,16'hFFE0,8'h00,8'hFF,8'h00));

        RST_N = 1'b0;
        drive(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        check_all(-1, 1'b0, 3'd0, 16'hFFE0, 8'h00, 8'h00, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;

        foreach (tbl[i]) begin
            @(negedge CLK);
            drive(tbl[i].irq, tbl[i].we, tbl[i].wd, tbl[i].gie, tbl[i].ack, tbl[i].reti, tbl[i].oclr);
            @(posedge CLK);
            #1;
            check_all(i, tbl[i].req, tbl[i].id, tbl[i].vec, tbl[i].pend, tbl[i].ie, tbl[i].ovf);
        end

        // Asynchronous reset while a request for PENDING=8'h05 is outstanding
        @(negedge CLK);
        drive(8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        drive(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        check_all(100, 1'b1, 3'd2, 16'hFFE4, 8'h05, 8'hFF, 8'h00);
        #2;
        RST_N = 1'b0;
        #1;
        check_all(101, 1'b0, 3'd0, 16'hFFE0, 8'h00, 8'h00, 8'h00);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        check_all(102, 1'b0, 3'd0, 16'hFFE0, 8'h00, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Maskable, fixed-priority interrupt controller sitting directly downstream of `timer` and the other peripherals. It captures one-cycle request pulses such as `timer.IRT` into pending latches, applies per-source and global enables, and selects the highest-priority source. It then presents a request with a vector address to the CPU core. A request/acknowledge/return handshake serialises servicing, with no nesting.

## Interface
Parameters:
- `N_SRC`, default 8: number of interrupt sources, 2..16.
- `VEC_BASE`, default 16'hFFE0: vector address of source 0.

Ports, clock and reset first:
- `CLK`, in, 1: system clock, rising edge.
- `RST_N`, in, 1: reset, asynchronous, active-low.
- `IRQ`, in, N_SRC: request pulses, one cycle high per event. Bit 0 is driven by `timer.IRT`.
- `IE_WE`, in, 1: write strobe for the enable register.
- `IE_WDATA`, in, N_SRC: new enable mask.
- `GIE`, in, 1: global interrupt enable from the CPU status register.
- `INT_ACK`, in, 1: one-cycle pulse from the CPU. It means "vector taken".
- `RETI`, in, 1: one-cycle pulse from the CPU. It means "handler returned".
- `OVF_CLR`, in, 1: clears all overflow flags.
- `INT_REQ`, out, 1: request to the CPU.
- `VECTOR`, out, 16: vector address, equal to VEC_BASE + 2*IRQ_ID.
- `IRQ_ID`, out, $clog2(N_SRC): index of the requesting source.
- `PENDING`, out, N_SRC: pending latches.
- `IE`, out, N_SRC: current enable mask.
- `OVF`, out, N_SRC: sticky lost-event flags.

## Operation
Pending latches:
- `PENDING[i]` sets on any cycle where `IRQ[i]`=1.
- It clears only on `INT_ACK` accepted for source i.
- If a set and a clear hit the same bit in the same cycle, set wins and the bit stays 1.
- `IRQ[i]`=1 while `PENDING[i]` is already 1, and not cleared that cycle, sets `OVF[i]`.
- `OVF_CLR` clears all OVF bits. If a new overflow occurs in the same cycle as `OVF_CLR`, the overflow wins.

Enable register:
- `IE` loads `IE_WDATA` on `IE_WE`.
- Masking never clears PENDING. A masked event stays pending until it is enabled.

Eligible sources:
- Eligible mask = PENDING & IE, evaluated only when `GIE`=1.
- Priority is fixed: the highest index wins.

FSM states are IDLE, REQ and SERVICE.
- IDLE → REQ: the eligible mask is nonzero. The winner index latches into `IRQ_ID`/`VECTOR`.
- REQ → SERVICE: on `INT_ACK`. `PENDING[IRQ_ID]` clears.
- REQ → IDLE: the request is withdrawn, with no ack, when `GIE`=0 or the latched source's IE bit is 0.
  - If `INT_ACK` arrives in the same cycle as a withdrawal condition, the ack wins.
- SERVICE → IDLE: on `RETI`.
- `IRQ_ID` stays stable throughout REQ. A higher-priority arrival does not re-arbitrate; it is served on the next IDLE→REQ transition.
- `INT_ACK` outside REQ is ignored. `RETI` outside SERVICE is ignored.
- New events are still captured into PENDING while in REQ or SERVICE.

## Timing
- Reset: state IDLE; INT_REQ=0, IRQ_ID=0, VECTOR=VEC_BASE, PENDING=0, IE=0, OVF=0.
- Reset mid-operation drops state to IDLE immediately and loses all pending events.
- All outputs are registered, or decoded only from registered state.
- Latency: `IRQ[i]` high in cycle 0, with source eligible → PENDING visible in cycle 1 → INT_REQ=1 from cycle 2.
- `INT_ACK` in cycle t → INT_REQ=0 and the PENDING bit clear from cycle t+1.
- `RETI` in cycle t → IDLE in t+1. The earliest next INT_REQ is t+2.
- `IE_WE` takes effect the following cycle.
- VECTOR arithmetic is 16-bit and the result is written with bit 0 = 0.

## Structure
- Shared package `irq_pkg` holds:
  - the state enum `irq_state_t` (IDLE, REQ, SERVICE);
  - the default `VEC_BASE` constant;
  - the `VEC_STRIDE` = 2 constant.
- One sub-module, `irq_prio_enc`, is parameterised by N_SRC. It is combinational: highest-set-bit index plus valid flag.
- The top level holds the latches, the FSM and the vector register.

## Test plan
- Reset values: hold RST_N=0 mid-REQ with PENDING=8'h05 → all outputs at reset values asynchronously, and stay there after release.
- Single timer event: IE=8'h01, GIE=1, IRQ[0] pulse in cycle 0 → INT_REQ=1 in cycle 2 with VECTOR=16'hFFE0. `INT_ACK` → PENDING=0. `RETI` → IDLE, no further request.
- Priority:
  - IRQ[2] and IRQ[5] pulse together, IE=8'hFF → IRQ_ID=5, VECTOR=16'hFFEA.
  - After ACK/RETI → IRQ_ID=2, VECTOR=16'hFFE4.
- Masking:
  - IE=0, IRQ[3] pulse → PENDING=8'h08, INT_REQ stays 0.
  - Write IE=8'h08 → INT_REQ=1 two cycles later.
  - Drop GIE during REQ → INT_REQ falls, PENDING keeps bit 3.
- Overflow and set-wins:
  - Two IRQ[1] pulses before ack → OVF[1]=1.
  - IRQ[1] in the same cycle as the ack of source 1 → PENDING[1] remains 1, OVF[1] not set.
  - `OVF_CLR` → OVF=0.
- Late higher-priority arrival: IRQ[7] during REQ for source 4 → IRQ_ID stays 4 until ACK. Source 7 is requested after RETI.
